// File: rtl/char_motion_ctrl_pkg.sv
// Shared game definitions: platform layout, physics constants and FSM encodings
// used by the character motion controller.
package char_motion_ctrl_pkg;

  localparam int PLATFORM_COUNT = 19;
  localparam int H_STEP         = 2;
  localparam int JUMP_V         = 12;
  localparam int MAX_FALL       = 8;
  localparam int FLOOR_LIMIT    = 767;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef struct packed {
    logic [10:0] x_start;
    logic [10:0] x_end;
    logic [10:0] y_top;
  } platform_t;

  // Level layout; index 0 is the floor, which stops short of the right edge so
  // a character walking off past x=900 falls out of the world and respawns.
  function automatic platform_t platform_at(input logic [4:0] idx);
    platform_t p;
    case (idx)
      5'd0:    p = '{11'd0,   11'd900,  11'd760};
      5'd1:    p = '{11'd200, 11'd650,  11'd595};
      5'd2:    p = '{11'd700, 11'd850,  11'd640};
      5'd3:    p = '{11'd50,  11'd180,  11'd680};
      5'd4:    p = '{11'd880, 11'd1000, 11'd600};
      5'd5:    p = '{11'd60,  11'd160,  11'd520};
      5'd6:    p = '{11'd450, 11'd560,  11'd470};
      5'd7:    p = '{11'd700, 11'd800,  11'd500};
      5'd8:    p = '{11'd900, 11'd1024, 11'd430};
      5'd9:    p = '{11'd20,  11'd120,  11'd380};
      5'd10:   p = '{11'd600, 11'd700,  11'd360};
      5'd11:   p = '{11'd780, 11'd900,  11'd320};
      5'd12:   p = '{11'd150, 11'd250,  11'd300};
      5'd13:   p = '{11'd420, 11'd520,  11'd250};
      5'd14:   p = '{11'd250, 11'd400,  11'd480};
      5'd15:   p = '{11'd650, 11'd760,  11'd200};
      5'd16:   p = '{11'd850, 11'd980,  11'd150};
      5'd17:   p = '{11'd100, 11'd200,  11'd120};
      5'd18:   p = '{11'd500, 11'd600,  11'd100};
      default: p = '{11'd0,   11'd0,    11'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/platform_hit_check.sv
// Combinational test of the candidate position against a single platform:
// one-way landing while falling, and foot support while standing.
module platform_hit_check
  import char_motion_ctrl_pkg::*;
#(
  parameter int CHAR_WIDTH = 25
) (
  input  platform_t   plat,
  input  logic [10:0] x_new,
  input  logic [11:0] feet_old,
  input  logic [11:0] feet_new,
  input  logic        air_mode,
  input  logic        falling,
  output logic        landing,
  output logic        support
);

  logic [11:0] x_right;
  logic [11:0] top;
  logic        overlap;

  assign x_right = {1'b0, x_new} + 12'(CHAR_WIDTH);
  assign top     = {1'b0, plat.y_top};
  assign overlap = (x_right > {1'b0, plat.x_start}) && (x_new < plat.x_end);

  // Feet must cross the top surface from above; rising never lands.
  assign landing = air_mode && falling && overlap && (feet_old <= top) && (feet_new >= top);
  assign support = !air_mode && overlap && (feet_new == top);

endmodule

// File: rtl/char_motion_ctrl.sv
// Per-frame character motion: computes a candidate move, scans the platform
// table one entry per cycle through a shared checker, then commits the result.
module char_motion_ctrl
  import char_motion_ctrl_pkg::*;
#(
  parameter int CHAR_WIDTH  = 25,
  parameter int CHAR_HEIGHT = 32,
  parameter int SPAWN_X     = 300,
  parameter int SPAWN_Y     = 563
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        on_ground,
  output logic        busy,
  output logic        update_done,
  output logic        overrun
);

  localparam logic [10:0] X_MAX    = 11'(1024 - CHAR_WIDTH);
  localparam logic [11:0] HEIGHT12 = 12'(CHAR_HEIGHT);

  logic [1:0]         state;
  logic [4:0]         scan_idx;
  logic signed [11:0] vy;
  logic [10:0]        x_cand;
  logic signed [11:0] y_cand;
  logic signed [11:0] vy_cand;
  logic               air_cand;
  logic               falling_cand;
  logic [11:0]        feet_old;
  logic               hit_found;
  logic               supported;
  logic [10:0]        hit_top;

  logic signed [12:0] x_step;
  logic [10:0]        x_calc;
  logic signed [11:0] vy_eff;
  logic signed [11:0] y_sum;
  logic signed [11:0] vy_inc;
  logic signed [11:0] y_calc;
  logic signed [11:0] vy_calc;
  logic               air_calc;
  logic [11:0]        feet_new;
  logic               landing;
  logic               support;
  platform_t          cur_plat;

  // Candidate move; a jump from the ground takes effect in the same frame.
  always_comb begin
    x_step = $signed({2'b00, xpos});
    if (btn_right && !btn_left)
      x_step = x_step + 13'(H_STEP);
    else if (btn_left && !btn_right)
      x_step = x_step - 13'(H_STEP);

    if (x_step < 0)
      x_calc = '0;
    else if (x_step > $signed({2'b00, X_MAX}))
      x_calc = X_MAX;
    else
      x_calc = x_step[10:0];

    air_calc = !on_ground || btn_jump;
    if (on_ground && btn_jump)
      vy_eff = 12'(-JUMP_V);
    else if (on_ground)
      vy_eff = '0;
    else
      vy_eff = vy;

    y_sum  = $signed({1'b0, ypos}) + vy_eff;
    vy_inc = vy_eff + 12'sd1;
    y_calc = y_sum;
    if (!air_calc)
      vy_calc = '0;
    else if (y_sum < 0) begin
      y_calc  = '0;
      vy_calc = '0;
    end else
      vy_calc = (vy_inc > 12'(MAX_FALL)) ? 12'(MAX_FALL) : vy_inc;
  end

  assign feet_new = $unsigned(y_cand) + HEIGHT12;
  assign cur_plat = platform_at(scan_idx);
  assign busy     = (state != ST_IDLE);

  platform_hit_check #(.CHAR_WIDTH(CHAR_WIDTH)) u_hit (
    .plat     (cur_plat),
    .x_new    (x_cand),
    .feet_old (feet_old),
    .feet_new (feet_new),
    .air_mode (air_cand),
    .falling  (falling_cand),
    .landing  (landing),
    .support  (support)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      scan_idx     <= '0;
      vy           <= '0;
      xpos         <= 11'(SPAWN_X);
      ypos         <= 11'(SPAWN_Y);
      on_ground    <= 1'b0;
      update_done  <= 1'b0;
      overrun      <= 1'b0;
      x_cand       <= '0;
      y_cand       <= '0;
      vy_cand      <= '0;
      air_cand     <= 1'b0;
      falling_cand <= 1'b0;
      feet_old     <= '0;
      hit_found    <= 1'b0;
      supported    <= 1'b0;
      hit_top      <= '0;
    end else begin
      update_done <= 1'b0;
      overrun     <= frame_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: if (frame_tick) state <= ST_CALC;
        ST_CALC: begin
          x_cand       <= x_calc;
          y_cand       <= y_calc;
          vy_cand      <= vy_calc;
          air_cand     <= air_calc;
          falling_cand <= !vy_eff[11];
          feet_old     <= {1'b0, ypos} + HEIGHT12;
          scan_idx     <= '0;
          hit_found    <= 1'b0;
          supported    <= 1'b0;
          state        <= ST_SCAN;
        end
        ST_SCAN: begin
          // Strict compare keeps the lowest index on equal heights.
          if (landing && (!hit_found || cur_plat.y_top < hit_top)) begin
            hit_found <= 1'b1;
            hit_top   <= cur_plat.y_top;
          end
          if (support) supported <= 1'b1;
          if (scan_idx == 5'(PLATFORM_COUNT - 1))
            state <= ST_COMMIT;
          else
            scan_idx <= scan_idx + 5'd1;
        end
        ST_COMMIT: begin
          if (hit_found) begin
            xpos      <= x_cand;
            ypos      <= hit_top - 11'(CHAR_HEIGHT);
            vy        <= '0;
            on_ground <= 1'b1;
          end else if (feet_new > 12'(FLOOR_LIMIT)) begin
            xpos      <= 11'(SPAWN_X);
            ypos      <= 11'(SPAWN_Y);
            vy        <= '0;
            on_ground <= 1'b0;
          end else begin
            xpos      <= x_cand;
            ypos      <= y_cand[10:0];
            vy        <= vy_cand;
            on_ground <= !air_cand && supported;
          end
          update_done <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
